regfile_wb_sink: RTL
====================

REGFILE_WB_SINK -- requirements
Module: regfile_wb_sink

Interface
REQ-001 Parameters: none; 8 registers R0..R7, 16 bits each, all fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 write_in  in  1  writeback enable from the writeback stage.
REQ-005 writenum_in  in  3  destination register of the writeback.
REQ-006 writeback_data_in  in  16  writeback value.
REQ-007 readnum_a_in, readnum_b_in  in  3 each  source register numbers, read ports A and B.
REQ-008 read_en_in  in  1  capture read ports this cycle.
REQ-009 reserve_in  in  1  decode marks a new in-flight write to reserve_num_in.
REQ-010 reserve_num_in  in  3  register being reserved.
REQ-011 flush_in  in  1  pipeline flush (delayed-branch taken); cancels all reservations.
REQ-012 data_a_out, data_b_out  out  16 each  registered read data.
REQ-013 stall_out  out  1  combinational; a requested source is pending.
REQ-014 reserve_ack_out  out  1  combinational; reservation accepted this cycle.

Function
REQ-015 Storage: 8x16 array; write on edge when write_in=1 and rst_n=1; no hardwired-zero register.
REQ-016 Read latency: exactly one cycle; data_x_out updates only on edges with read_en_in=1, otherwise holds.
REQ-017 Bypass: if write_in=1 and writenum_in equals a read port number in the same capture cycle, that port captures writeback_data_in, not the old array value.
REQ-018 Scoreboard: per register, a 2-bit pending counter pend[r], range 0..3.
REQ-019 Reserve accepted when reserve_in=1, flush_in=0 and pend[reserve_num_in]<3, or when it is 3 and a write to the same register occurs that cycle; reserve_ack_out=1 exactly then, else 0.
REQ-020 Write with write_in=1 decrements pend[writenum_in] if nonzero; write to a register with pend=0 is still performed, and the counter stays 0 (no underflow).
REQ-021 Simultaneous accepted reserve and write to the same register: counter unchanged.
REQ-022 Accepted reserve and write to different registers: both counters updated independently in the same edge.
REQ-023 flush_in=1: all pend[r] cleared to 0 on that edge; any write that cycle still updates the array; reserve_in ignored (ack=0).
REQ-024 stall_out=1 when read_en_in=1 and, for port A or B, pend[readnum]>1, or pend[readnum]=1 and no write to that register this cycle; else 0.
REQ-025 When stall_out=1, data outputs still capture per REQ-016; the consumer discards them and re-presents the read.
REQ-026 stall_out and reserve_ack_out are 0 while rst_n=0.

Reset
REQ-027 On an edge with rst_n=0: all 8 registers to 0x0000, all pend to 0, data_a_out and data_b_out to 0x0000; write, reserve and read inputs ignored.
REQ-028 Reset mid-operation discards outstanding reservations; first edge after rst_n returns to 1 operates normally.

Verification
REQ-029 Reset, then write R3=0x1234; next cycle read A=R3 -> data_a_out=0x1234 one cycle after read_en_in.
REQ-030 Same cycle write R5=0xBEEF and read B=R5 -> data_b_out=0xBEEF next cycle; stall_out=0.
REQ-031 Reserve R2 three times -> ack=1,1,1; fourth reserve -> ack=0; read R2 -> stall_out=1; three writes to R2 -> pend=0, stall_out=0.
REQ-032 pend[R4]=1, read R4 while writing R4=0x00AA -> stall_out=0, data=0x00AA.
REQ-033 pend[R1]=2, pend[R6]=1, flush_in=1 with reserve_in=1 -> ack=0, all pend=0 next cycle, reads of R1/R6 do not stall.
REQ-034 rst_n=0 asserted while write_in=1 to R7=0xFFFF -> R7 reads 0x0000 after reset; outputs 0x0000.

Source files
------------

// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink: 8x16 register file with one writeback port, two registered
// read ports with same-cycle writeback bypass, and a per-register 2-bit
// pending-write scoreboard that drives stall and reservation acknowledge.
module regfile_wb_sink (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        write_in,
   input  logic [2:0]  writenum_in,
   input  logic [15:0] writeback_data_in,
   input  logic [2:0]  readnum_a_in,
   input  logic [2:0]  readnum_b_in,
   input  logic        read_en_in,
   input  logic        reserve_in,
   input  logic [2:0]  reserve_num_in,
   input  logic        flush_in,
   output logic [15:0] data_a_out,
   output logic [15:0] data_b_out,
   output logic        stall_out,
   output logic        reserve_ack_out
);

   logic [15:0] regs [8];
   logic [1:0]  pend [8];
   logic        stall_a;
   logic        stall_b;

   // A source is pending if more than one write is outstanding, or exactly one
   // that is not being retired by the writeback in this same cycle.
   always_comb begin
      stall_a = (pend[readnum_a_in] > 2'd1) ||
                ((pend[readnum_a_in] == 2'd1) && !(write_in && (writenum_in == readnum_a_in)));
      stall_b = (pend[readnum_b_in] > 2'd1) ||
                ((pend[readnum_b_in] == 2'd1) && !(write_in && (writenum_in == readnum_b_in)));
      stall_out = rst_n && read_en_in && (stall_a || stall_b);
   end

   // A saturated counter still accepts a reserve when a write retires one slot
   // of the same register this cycle.
   always_comb begin
      reserve_ack_out = rst_n && reserve_in && !flush_in &&
                        ((pend[reserve_num_in] != 2'd3) ||
                         (write_in && (writenum_in == reserve_num_in)));
   end

   // Array writes and read-port capture with writeback bypass.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 8; r++) regs[r] <= '0;
         data_a_out <= '0;
         data_b_out <= '0;
      end else begin
         if (write_in) regs[writenum_in] <= writeback_data_in;
         if (read_en_in) begin
            data_a_out <= (write_in && (writenum_in == readnum_a_in)) ? writeback_data_in
                                                                       : regs[readnum_a_in];
            data_b_out <= (write_in && (writenum_in == readnum_b_in)) ? writeback_data_in
                                                                       : regs[readnum_b_in];
         end
      end
   end

   // Scoreboard: reserve increments, write decrements (floored at 0), a
   // reserve and write to the same register cancel, flush clears everything.
   always_ff @(posedge clk) begin
      if (!rst_n || flush_in) begin
         for (int r = 0; r < 8; r++) pend[r] <= '0;
      end else begin
         for (int r = 0; r < 8; r++) begin
            if (reserve_ack_out && (reserve_num_in == 3'(r)) &&
                write_in && (writenum_in == 3'(r)))
               pend[r] <= pend[r];
            else if (reserve_ack_out && (reserve_num_in == 3'(r)))
               pend[r] <= pend[r] + 2'd1;
            else if (write_in && (writenum_in == 3'(r)) && (pend[r] != 2'd0))
               pend[r] <= pend[r] - 2'd1;
         end
      end
   end

endmodule
